// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit
//
// Purpose: multi-cycle shift-add multiplier and restoring divider for the
// M extension. One request is accepted while idle. It then runs XLEN
// iterations, applies the sign fix, and pulses done with the result.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - request, accepted only while idle
//   op     - func3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b   - rs1 / rs2 operands, latched on accept
//   busy   - high while iterating
//   done   - one-cycle pulse, result valid
//   result - operation result, held until overwritten by the next completion

module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    // hi: running product high half / partial remainder
    // lo: multiplier being shifted out / dividend becoming quotient
    // mcand: multiplicand / divisor magnitude
    logic [XLEN:0]   hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN:0]   mcand_q, mcand_d;
    logic            neg_q, neg_d;
    logic            special_q, special_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;

    // Operand decode for the incoming request
    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN:0]   ext_a, ext_b, mag_a, mag_b;
    logic            b_zero, ovf, special_in;
    logic [XLEN-1:0] special_val;

    assign a_sgn = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    assign b_sgn = op[2] ? ~op[0] : ~op[1];
    assign a_neg = a_sgn & a[XLEN-1];
    assign b_neg = b_sgn & b[XLEN-1];
    // 33-bit magnitudes so that the most negative value keeps its magnitude
    assign ext_a = {a_neg, a};
    assign ext_b = {b_neg, b};
    assign mag_a = a_neg ? -ext_a : ext_a;
    assign mag_b = b_neg ? -ext_b : ext_b;

    assign b_zero      = (b == '0);
    assign ovf         = op[2] & ~op[0] & (a == MIN_NEG) & (b == '1);
    assign special_in  = op[2] & (b_zero | ovf);
    assign special_val = b_zero ? (op[1] ? a : '1) : (op[1] ? '0 : MIN_NEG);

    // One multiply step: conditional add, then shift {sum, lo} right by one
    logic [XLEN:0]   addend, sum;
    assign addend = lo_q[0] ? mcand_q : '0;
    assign sum    = {1'b0, hi_q[XLEN-1:0]} + addend;

    // One divide step: shift {rem, dividend msb} left and trial-subtract
    logic [XLEN+1:0] shifted;
    logic            ge;
    assign shifted = {hi_q, lo_q[XLEN-1]};
    assign ge      = (shifted >= {1'b0, mcand_q});

    // Sign fix-up of the finished magnitudes
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    assign prod     = {hi_q[XLEN-1:0], lo_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -lo_q : lo_q;
    assign rem_fix  = neg_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        neg_d     = neg_q;
        special_d = special_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = '0;
                    hi_d  = '0;
                    // DIV/REM sign: quotient takes a^b, remainder follows a
                    neg_d = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
                    if (special_in) begin
                        special_d = 1'b1;
                        lo_d      = special_val;
                        mcand_d   = '0;
                        state_d   = S_FIN;
                    end else begin
                        special_d = 1'b0;
                        busy_d    = 1'b1;
                        state_d   = S_CALC;
                        if (op[2]) begin
                            lo_d    = mag_a[XLEN-1:0];
                            mcand_d = mag_b;
                        end else begin
                            lo_d    = mag_b[XLEN-1:0];
                            mcand_d = mag_a;
                        end
                    end
                end
            end

            S_CALC: begin
                if (op_q[2]) begin
                    hi_d = ge ? (XLEN+1)'(shifted - {1'b0, mcand_q}) : shifted[XLEN:0];
                    lo_d = {lo_q[XLEN-2:0], ge};
                end else begin
                    hi_d = {1'b0, sum[XLEN:1]};
                    lo_d = {sum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) begin
                    busy_d  = 1'b0;
                    state_d = S_FIN;
                end
            end

            S_FIN: begin
                if (special_q) begin
                    result_d = lo_q;
                end else begin
                    case (op_q)
                        3'b000:                 result_d = prod_fix[XLEN-1:0];
                        3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
                        3'b100, 3'b101:         result_d = quo_fix;
                        default:                result_d = rem_fix;
                    endcase
                end
                special_d = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit

module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    mul_div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the RV32M definitions
    function automatic logic [31:0] ref_fn(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p;
        logic ovf;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                sx = (o != 3'd3) ? longint'($signed(x)) : longint'({32'd0, x});
                sy = (o < 3'd2)  ? longint'($signed(y)) : longint'({32'd0, y});
                p  = sx * sy;
                return (o == 3'd0) ? p[31:0] : p[63:32];
            end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return 32'(int'(x) / int'(y));
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (ovf)    return 32'd0;
                return 32'(int'(x) % int'(y));
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (!o[2]) return 1'b0;
        if (y == 0) return 1'b1;
        return (o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
    endfunction

    // Transaction-level model: a request is taken only when nothing is in
    // flight; done appears 33 edges later (1 edge for special cases).
    bit          m_active = 1'b0;
    bit          m_special = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res = 32'd0;
    logic [31:0] exp_result = 32'd0;
    bit          exp_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active   <= 1'b0;
            m_special  <= 1'b0;
            m_left     <= 0;
            exp_done   <= 1'b0;
            exp_result <= 32'd0;
        end else begin
            exp_done <= 1'b0;
            if (m_active) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_active   <= 1'b0;
                    exp_done   <= 1'b1;
                    exp_result <= m_res;
                end
            end else if (start) begin
                m_active  <= 1'b1;
                m_special <= is_special(op, a, b);
                m_left    <= is_special(op, a, b) ? 1 : 33;
                m_res     <= ref_fn(op, a, b);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            check("busy",   busy,   m_active && !m_special && (m_left > 1));
            check("done",   done,   exp_done);
            check("result", result, exp_result);
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] lit, input int lat, input int inj, input string nm);
        int  t0;
        int  nbusy;
        bit  got;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        t0 = cyc; nbusy = 0; got = 1'b0;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
            if (inj != 0 && cyc - t0 == inj) begin
                start = 1'b1; op = 3'd5; a = $urandom; b = $urandom | 32'd1;
            end else begin
                start = 1'b0;
            end
        end
        check({nm, "_latency"}, got ? (cyc - t0) : 999, lat);
        check({nm, "_busy_cycles"}, nbusy, (lat == 34) ? 32 : 0);
        check({nm, "_result"}, result, lit);
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        check("reset_busy",   busy,   1'b0);
        check("reset_done",   done,   1'b0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Model pins against hand-computed values
        check("pin_mul",    ref_fn(3'd0, 32'd7, 32'hFFFF_FFFD),          32'hFFFF_FFEB);
        check("pin_mulh",   ref_fn(3'd1, 32'h8000_0000, 32'h8000_0000),  32'h4000_0000);
        check("pin_mulhsu", ref_fn(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF),  32'hFFFF_FFFF);
        check("pin_rem",    ref_fn(3'd6, 32'hFFFF_FFF9, 32'd2),          32'hFFFF_FFFF);

        run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0, "mul");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0, "mulh");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0, "mulhsu");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0, "mulhu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0, "rem");
        run_op(3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 34, 0, "divu");
        run_op(3'd7, 32'hFFFF_FFF9, 32'd2,         32'd1,         34, 0, "remu");
        run_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 2,  0, "divu_by0");
        run_op(3'd7, 32'd5,         32'd0,         32'd5,         2,  0, "remu_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  0, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2,  0, "rem_ovf");

        // Second request during the operation must be ignored
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 10, "mul_hs");
        repeat (5) @(negedge clk);
        check("result_hold", result, 32'hFFFF_FFEB);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd7; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc - t0 < 15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy",   busy,   1'b0);
        check("midrst_done",   done,   1'b0);
        check("midrst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_op(3'd4, 32'd1000, 32'd7, 32'd142, 34, 0, "div_after_rst");

        // Randomized traffic, including start pulses while busy
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            op    = 3'($urandom);
            a     = pick();
            b     = pick();
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the RV32M extension in the multi-cycle CPU datapath.
- Sits directly downstream of the controller, beside the ALU. The controller decodes func7 = 0000001 on an R-type instruction and issues start with func3 as op, then holds its execute state until done.
- Computes via a 32-step shift-add multiplier or restoring divider. result feeds the result mux.

Parameters:
- XLEN, 32, operand/result width. The iteration count equals XLEN.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request, sampled on rising clk; accepted only when busy = 0
- op  input  3  func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  XLEN  rs1 operand, latched on accept
- b  input  XLEN  rs2 operand, latched on accept
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  operation result, held until the next accept or reset

Behaviour:
- Reset (async, rst = 1): state = IDLE, busy = 0, done = 0, result = 0, counter = 0, internal registers = 0. This applies mid-operation: the operation is abandoned and no done pulse is produced.
- States: IDLE, CALC, FIN.
- IDLE:
  - On start = 1, latch op, a and b, and compute operand magnitudes and result sign.
  - If a special divide case applies, go to FIN. Otherwise go to CALC with counter = 0 and busy = 1.
- CALC (busy = 1):
  - One iteration per cycle. Multiply: conditional add of the multiplicand and a 64-bit shift right. Divide: restoring shift-subtract producing one quotient bit.
  - Leave for FIN when counter = XLEN-1. CALC therefore lasts exactly 32 cycles.
- FIN:
  - Apply the sign fix, write result, pulse done = 1 for exactly one cycle, busy = 0, then return to IDLE.
  - start in FIN is ignored; it is accepted only in IDLE.
- Latency, normal case: done is high in the cycle after the 33rd rising edge following the accepting edge. That is 34 cycles from start to done.
- Latency, special case: done is high in the cycle after the 1st edge following accept.
- start while busy = 1: ignored. Latched operands and op are unaffected.
- Operand changes after accept: no effect.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Magnitudes are computed in 33-bit form so that -2^31 is handled.
- Results:
  - MUL: low 32 bits of the 64-bit product.
  - MULH, MULHSU, MULHU: high 32 bits of the correctly signed 64-bit product.
  - DIV/DIVU: quotient truncated toward zero.
  - REM/REMU: remainder, which takes the sign of the dividend.
- Special cases, resolved without CALC:
  - DIV or DIVU with b = 0: result = 0xFFFFFFFF.
  - REM or REMU with b = 0: result = a.
  - DIV with a = 0x80000000 and b = 0xFFFFFFFF: result = 0x80000000.
  - REM with the same operands: result = 0.
- Multiply special values (0, -1, -2^31) take the normal path; no early exit.

Test Plan:
- MUL: a = 7, b = 0xFFFFFFFD -> result = 0xFFFFFFEB. done is a single-cycle pulse exactly 34 cycles after the start cycle, and busy is high for the 32 CALC cycles in between.
- MULH and MULHSU:
  - MULH with a = 0x80000000, b = 0x80000000 -> 0x40000000.
  - MULHSU with a = 0xFFFFFFFF, b = 0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU with the same operands -> 0xFFFFFFFE.
- Divide and remainder:
  - DIV -7/2 (a = 0xFFFFFFF9, b = 2) -> 0xFFFFFFFD.
  - REM with the same operands -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
  - REMU with the same operands -> 1.
- Special cases, each with done in the cycle after accept and no CALC:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Handshake: start a MUL; at cycle 10 re-assert start with different op, a and b. The second request is ignored and the first result is returned. result holds after done until the next accept.
- Reset mid-operation: assert rst asynchronously at cycle 15 of a DIV. busy, done and result go to 0 immediately, and no done pulse follows. A new DIV after reset completes correctly in 34 cycles.
